// File: rtl/mig_ui_responder_if.sv
// MIG user-side command/data link between an initiator (bridge) and the
// responder that stands in for the memory controller.
interface mig_ui_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 28
) ();
    logic                  en_i;
    logic                  w_en_i;
    logic [ADDR_W-1:0]     addr_i;
    logic [DATA_W-1:0]     data_i;
    logic [DATA_W/8-1:0]   strb_i;
    logic                  ready_o;
    logic                  w_ready_o;
    logic [DATA_W-1:0]     data_o;
    logic                  valid_o;
    logic [31:0]           rd_cnt_o;
    logic [31:0]           wr_cnt_o;

    modport master (
        output en_i, w_en_i, addr_i, data_i, strb_i,
        input  ready_o, w_ready_o, data_o, valid_o, rd_cnt_o, wr_cnt_o
    );

    modport slave (
        input  en_i, w_en_i, addr_i, data_i, strb_i,
        output ready_o, w_ready_o, data_o, valid_o, rd_cnt_o, wr_cnt_o
    );
endinterface

// File: rtl/mig_ui_responder.sv
// Behavioural MIG user-interface responder: byte-strobed word store, fixed
// latency read return and programmable command/write backpressure.
module mig_ui_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 28,
    parameter int DEPTH       = 256,
    parameter int RD_LATENCY  = 4,
    parameter int BUSY_CYCLES = 0,
    parameter int W_GAP       = 1
) (
    input  logic              ui_clk_i,
    input  logic              ui_rst_i,
    mig_ui_responder_if.slave ui
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int GAP_MAX = BUSY_CYCLES + W_GAP;
    localparam int CNT_W   = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_BUSY  = 2'd2,
        ST_WGAP  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [CNT_W-1:0]    busy_cnt_r;
    logic [CNT_W-1:0]    busy_cnt_s;
    logic [CNT_W-1:0]    wgap_cnt_r;
    logic [CNT_W-1:0]    wgap_cnt_s;
    logic                ready_s;
    logic                w_ready_s;
    logic                acc_s;
    logic                rd_acc_s;
    logic                wr_acc_s;
    logic [IDX_W-1:0]    idx_s;
    logic                addr_unused_s;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [RD_LATENCY-1:0] stage_v_r;
    logic [DATA_W-1:0]   stage_d_r [RD_LATENCY];
    logic [31:0]         rd_cnt_r;
    logic [31:0]         wr_cnt_r;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    // Upper address bits alias onto the storage index.
    assign idx_s         = ui.addr_i[IDX_W-1:0];
    assign addr_unused_s = ^ui.addr_i;

    assign acc_s    = ui.en_i & ready_s & (~ui.w_en_i | w_ready_s);
    assign rd_acc_s = acc_s & ~ui.w_en_i;
    assign wr_acc_s = acc_s & ui.w_en_i;

    // State register and backpressure countdowns.
    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) begin
            state_r    <= ST_RESET;
            busy_cnt_r <= '0;
            wgap_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            busy_cnt_r <= busy_cnt_s;
            wgap_cnt_r <= wgap_cnt_s;
        end
    end

    // Next-state: state follows whichever countdown is still running.
    always_comb begin
        busy_cnt_s = busy_cnt_r;
        wgap_cnt_s = wgap_cnt_r;
        state_s    = state_r;
        if (acc_s) begin
            busy_cnt_s = CNT_W'(BUSY_CYCLES);
        end else if (busy_cnt_r != '0) begin
            busy_cnt_s = busy_cnt_r - CNT_W'(1);
        end else begin
            busy_cnt_s = busy_cnt_r;
        end
        if (wr_acc_s) begin
            wgap_cnt_s = CNT_W'(GAP_MAX);
        end else if (wgap_cnt_r != '0) begin
            wgap_cnt_s = wgap_cnt_r - CNT_W'(1);
        end else begin
            wgap_cnt_s = wgap_cnt_r;
        end
        case (state_r)
            ST_RESET: state_s = ST_READY;
            default: begin
                if (busy_cnt_s != '0) begin
                    state_s = ST_BUSY;
                end else if (wgap_cnt_s != '0) begin
                    state_s = ST_WGAP;
                end else begin
                    state_s = ST_READY;
                end
            end
        endcase
    end

    // Output decode: WGAP still takes reads but refuses writes.
    always_comb begin
        ready_s   = 1'b0;
        w_ready_s = 1'b0;
        case (state_r)
            ST_READY: begin
                ready_s   = 1'b1;
                w_ready_s = 1'b1;
            end
            ST_WGAP: begin
                ready_s   = 1'b1;
                w_ready_s = 1'b0;
            end
            default: begin
                ready_s   = 1'b0;
                w_ready_s = 1'b0;
            end
        endcase
    end

    // Storage is never cleared, so it survives a reset.
    always_ff @(posedge ui_clk_i) begin
        if (wr_acc_s && !ui_rst_i) begin
            mem_r[idx_s] <= merge_bytes(mem_r[idx_s], ui.data_i, ui.strb_i);
        end
    end

    // Read-return pipeline; data stages only load behind a valid so the tail holds.
    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) begin
            stage_v_r <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                stage_d_r[k] <= '0;
            end
        end else begin
            stage_v_r[0] <= rd_acc_s;
            if (rd_acc_s) begin
                stage_d_r[0] <= mem_r[idx_s];
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                stage_v_r[k] <= stage_v_r[k-1];
                if (stage_v_r[k-1]) begin
                    stage_d_r[k] <= stage_d_r[k-1];
                end
            end
        end
    end

    // Accepted-command counters, free-running with natural wrap.
    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) begin
            rd_cnt_r <= 32'd0;
            wr_cnt_r <= 32'd0;
        end else begin
            if (rd_acc_s) begin
                rd_cnt_r <= rd_cnt_r + 32'd1;
            end
            if (wr_acc_s) begin
                wr_cnt_r <= wr_cnt_r + 32'd1;
            end
        end
    end

    assign ui.ready_o   = ready_s;
    assign ui.w_ready_o = w_ready_s;
    assign ui.valid_o   = stage_v_r[RD_LATENCY-1];
    assign ui.data_o    = stage_d_r[RD_LATENCY-1];
    assign ui.rd_cnt_o  = rd_cnt_r;
    assign ui.wr_cnt_o  = wr_cnt_r;
endmodule
